mult_limb_scheduler: RTL

//  Sequences one 56-bit limb-slice multiplier (upper/middle slice pair) across a long-integer product.

---
 rtl/mult_sched_pkg.sv | 24 ++
 rtl/mult_limb_scheduler_if.sv | 39 +++
 rtl/mult_sched_idx_cnt.sv | 55 +++++
 rtl/mult_limb_scheduler.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the limb-pair multiply scheduler.
// Optional performance counters are enabled with SCHED_PERF_CNT_EN.
package mult_sched_pkg;

    localparam int LIMB_W    = 56;
    localparam int MAX_LIMBS = 55;
    localparam int IDX_W     = 6;

    typedef logic [IDX_W-1:0] limb_idx_t;
    typedef logic [IDX_W:0]   col_idx_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } sched_state_e;

    function automatic logic len_ok(input limb_idx_t n);
        return (n != '0) && (n <= limb_idx_t'(MAX_LIMBS));
    endfunction

endpackage

// File: rtl/mult_limb_scheduler_if.sv
// Bundle of control, multiplier and accumulator signals around the scheduler.
// master = scheduler side, slave = operand store / datapath side.
interface mult_limb_scheduler_if;
    import mult_sched_pkg::*;

    logic         start;
    logic         abort;
    limb_idx_t    na;
    limb_idx_t    nb;
    logic         busy;
    logic         done;
    logic         len_err;
    limb_idx_t    a_idx;
    limb_idx_t    b_idx;
    logic         mul_en;
    logic         mul_done;
    logic         acc_wr;
    col_idx_t     acc_col;
    logic         acc_clr;
    logic         acc_ready;
    logic [31:0]  cyc_cnt;
    logic [31:0]  stall_cnt;
    sched_state_e dbg_state;

    // mul_en/mul_done are single-cycle pulses; acc_wr is a valid held until acc_ready
    // is seen high on the same edge, and a write transfers only on acc_wr && acc_ready.
    modport master (
        input  start, abort, na, nb, mul_done, acc_ready,
        output busy, done, len_err, a_idx, b_idx, mul_en,
               acc_wr, acc_col, acc_clr, cyc_cnt, stall_cnt, dbg_state
    );

    modport slave (
        output start, abort, na, nb, mul_done, acc_ready,
        input  busy, done, len_err, a_idx, b_idx, mul_en,
               acc_wr, acc_col, acc_clr, cyc_cnt, stall_cnt, dbg_state
    );

endinterface

// File: rtl/mult_sched_idx_cnt.sv
// Nested (i outer, j inner) limb-pair counter with clear, advance and last-pair flag.
// Advancing past the last pair wraps both indices back to zero.
module mult_sched_idx_cnt
    import mult_sched_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clr_i,
    input  logic      adv_i,
    input  limb_idx_t na_i,
    input  limb_idx_t nb_i,
    output limb_idx_t i_o,
    output limb_idx_t j_o,
    output logic      last_o
);

    limb_idx_t i_q, i_d;
    limb_idx_t j_q, j_d;
    logic      j_last;

    assign j_last = (j_q == limb_idx_t'(nb_i - 1'b1));
    assign last_o = j_last && (i_q == limb_idx_t'(na_i - 1'b1));
    assign i_o    = i_q;
    assign j_o    = j_q;

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
        end else if (adv_i) begin
            if (last_o) begin
                i_d = '0;
                j_d = '0;
            end else if (j_last) begin
                i_d = i_q + 1'b1;
                j_d = '0;
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

endmodule

// File: rtl/mult_limb_scheduler.sv
// Walks all (i,j) limb pairs, issuing one multiply per pair and writing to column i+j.
// Define SCHED_PERF_CNT_EN to enable the cyc_cnt/stall_cnt performance counters.
module mult_limb_scheduler
    import mult_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mult_limb_scheduler_if.master bus
);

    sched_state_e state_q, state_d;
    limb_idx_t    na_q, na_d;
    limb_idx_t    nb_q, nb_d;
    logic         len_err_q, len_err_d;
    logic         accept;
    logic         lens_ok;
    logic         cnt_clr;
    logic         cnt_adv;
    logic         cnt_last;
    logic         active;
    limb_idx_t    i_idx;
    limb_idx_t    j_idx;

    assign accept  = (state_q == IDLE) && bus.start && !bus.abort;
    assign lens_ok = len_ok(bus.na) && len_ok(bus.nb);

    mult_sched_idx_cnt u_idx_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .adv_i  (cnt_adv),
        .na_i   (na_q),
        .nb_i   (nb_q),
        .i_o    (i_idx),
        .j_o    (j_idx),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        na_d      = na_q;
        nb_d      = nb_q;
        len_err_d = len_err_q;
        cnt_clr   = 1'b0;
        cnt_adv   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    na_d      = bus.na;
                    nb_d      = bus.nb;
                    len_err_d = !lens_ok;
                    cnt_clr   = 1'b1;
                    state_d   = lens_ok ? ISSUE : DONE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.mul_done) state_d = WRITE;
            end
            WRITE: begin
                if (bus.acc_ready) begin
                    cnt_adv = 1'b1;
                    state_d = cnt_last ? DONE : ISSUE;
                end
            end
            DONE: begin
                len_err_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort drops the run without a done pulse and restores reset values.
        if (bus.abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            na_d      = '0;
            nb_d      = '0;
            len_err_d = 1'b0;
            cnt_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            na_q      <= '0;
            nb_q      <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            na_q      <= na_d;
            nb_q      <= nb_d;
            len_err_q <= len_err_d;
        end
    end

    assign active = (state_q == ISSUE) || (state_q == WAIT) || (state_q == WRITE);

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE);
        bus.len_err   = (state_q == DONE) && len_err_q;
        bus.mul_en    = (state_q == ISSUE);
        bus.acc_wr    = (state_q == WRITE);
        bus.acc_clr   = (state_q == WRITE) && (i_idx == '0) && (j_idx == '0);
        bus.a_idx     = active ? i_idx : '0;
        bus.b_idx     = active ? j_idx : '0;
        bus.acc_col   = active ? (col_idx_t'(i_idx) + col_idx_t'(j_idx)) : '0;
        bus.dbg_state = state_q;
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if (accept) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (state_q != IDLE) cyc_q <= cyc_q + 32'd1;
            if ((state_q == WRITE) && !bus.acc_ready) stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.cyc_cnt   = cyc_q;
    assign bus.stall_cnt = stall_q;
`else
    assign bus.cyc_cnt   = '0;
    assign bus.stall_cnt = '0;
`endif

endmodule
